hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised hazard/forwarding controller for the five-stage pipelined CPU.
- Drives the fetch stall, decode stall, execute flush and execute forward selects that the pipeline stages already consume.
- Adds decode-stage branch-compare forwarding, a multi-cycle multiply/divide busy interlock with its own stall FSM, and an optional stall-cycle performance counter.

Parameters:
- REG_ID_W, 5, register-specifier width. Register 0 is never a hazard source.
- MD_LATENCY, 4, total EX cycles of a mult/div op. Must be >= 1; a value of 1 disables the interlock.
- CNT_W, 32, width of the performance counter.

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- rs_id_d  in  REG_ID_W  decode Rs
- rt_id_d  in  REG_ID_W  decode Rt
- branch_d  in  1  decode holds a branch/jump that compares registers
- rs_id_e  in  REG_ID_W  execute Rs
- rt_id_e  in  REG_ID_W  execute Rt
- write_reg_e  in  REG_ID_W  execute destination register
- reg_write_e  in  1  execute register write enable
- mem_to_reg_e  in  1  execute is a load
- md_start_e  in  1  execute holds a mult/div in its first cycle
- write_reg_m  in  REG_ID_W  memory destination register
- reg_write_m  in  1  memory register write enable
- mem_to_reg_m  in  1  memory is a load
- write_reg_w  in  REG_ID_W  writeback destination register
- reg_write_w  in  1  writeback register write enable
- stall_f  out  1  hold PC
- stall_d  out  1  hold IF/ID register
- stall_e  out  1  hold ID/EX register
- flush_e  out  1  bubble into ID/EX
- flush_m  out  1  bubble into EX/MEM
- forward_a_d  out  1  decode compare operand A taken from ALUOutM
- forward_b_d  out  1  decode compare operand B taken from ALUOutM
- forward_a_e  out  2  execute operand A: 00 regfile, 01 ResultW, 10 ALUOutM
- forward_b_e  out  2  execute operand B, same encoding as forward_a_e
- md_busy  out  1  mult/div interlock active
- stall_cycles  out  CNT_W  performance counter

Behaviour:
- Reset is asynchronous and active-high. The clock is clock.
  - While reset is high: every output is 0, the FSM is IDLE, md_cnt is 0 and stall_cycles is 0.
- A register "matches" only when it is nonzero and equal.
- Execute forwarding (combinational):
  - forward_a_e = 10 if reg_write_m and write_reg_m matches rs_id_e.
  - Otherwise forward_a_e = 01 if reg_write_w and write_reg_w matches rs_id_e.
  - Otherwise forward_a_e = 00.
  - forward_b_e is the same, using rt_id_e. The memory stage has priority over writeback.
- Decode forwarding: forward_a_d = reg_write_m and write_reg_m matches rs_id_d. forward_b_d is the same with rt_id_d.
- lw_stall = mem_to_reg_e and reg_write_e and write_reg_e matches rs_id_d or rt_id_d.
- br_stall = branch_d and either of:
  - reg_write_e and write_reg_e matches rs_id_d or rt_id_d;
  - mem_to_reg_m and write_reg_m matches rs_id_d or rt_id_d.
- Mult/div FSM (registered), with states IDLE and BUSY and a down-counter md_cnt of width clog2(MD_LATENCY)+1:
  - IDLE: md_start_e and MD_LATENCY > 1 at a clock edge -> BUSY, md_cnt = MD_LATENCY-1.
  - BUSY: each edge decrements md_cnt. When md_cnt == 1 at an edge -> IDLE, md_cnt = 0.
  - md_start_e while BUSY is ignored.
  - md_busy = (state == BUSY). An op is therefore busy for exactly MD_LATENCY-1 cycles after its first EX cycle.
- Combining outputs:
  - stall_f = stall_d = lw_stall | br_stall | md_busy.
  - stall_e = md_busy.
  - flush_e = (lw_stall | br_stall) & ~md_busy. An instruction held in ID/EX is never flushed.
  - flush_m = md_busy.
- Simultaneous load-use and mult/div busy: md_busy dominates. The load-use hazard is re-evaluated after the FSM returns to IDLE.
- Reset asserted mid-BUSY returns the FSM to IDLE immediately. No stall persists after reset deasserts.
- Latency:
  - Forward, stall and flush outputs are combinational from the inputs in the same cycle.
  - md_busy is registered, with one edge of latency after md_start_e.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined: stall_cycles increments by 1 on every clock edge where stall_f is 1. It saturates at all-ones and never wraps, and resets to 0.
- When undefined: stall_cycles is tied to 0 and no counter flops exist.

Test Plan:
- Forward priority: reg_write_m=1, write_reg_m=5, reg_write_w=1, write_reg_w=5, rs_id_e=5 -> forward_a_e=10. Set reg_write_m=0 -> forward_a_e=01. Set rs_id_e=0 with writes to reg 0 -> forward_a_e=00.
- Load-use: mem_to_reg_e=1, reg_write_e=1, write_reg_e=8, rt_id_d=8 -> stall_f=stall_d=flush_e=1 for one cycle, stall_e=0. Clearing mem_to_reg_e -> all 0.
- Branch: branch_d=1, rs_id_d=3, reg_write_e=1, write_reg_e=3 -> stall plus flush_e=1. Next cycle with write_reg_m=3 and mem_to_reg_m=0 -> no stall, forward_a_d=1.
- Mult/div: MD_LATENCY=4, pulse md_start_e for one cycle -> md_busy, stall_e and flush_m high for exactly 3 cycles, then 0. With MD_LATENCY=1 -> never busy.
- Reset mid-BUSY, then load-use during BUSY: assert reset at cycle 2 of BUSY -> all outputs 0 immediately, IDLE after release. Load-use raised during BUSY -> flush_e=0 until md_busy drops, then flush_e=1.
- HAZARD_PERF_EN with CNT_W=4: 20 stalled cycles -> stall_cycles saturates at 15. Without the macro -> stall_cycles stays 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the five-stage pipeline, with a mult/div busy interlock.
// Define HAZARD_PERF_EN to build the saturating stall-cycle counter; otherwise o_stall_cycles is tied to 0.
module hazard_ctrl #(
    parameter int REG_ID_W   = 5,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [REG_ID_W-1:0] i_rs_id_d,
    input  logic [REG_ID_W-1:0] i_rt_id_d,
    input  logic                i_branch_d,
    input  logic [REG_ID_W-1:0] i_rs_id_e,
    input  logic [REG_ID_W-1:0] i_rt_id_e,
    input  logic [REG_ID_W-1:0] i_write_reg_e,
    input  logic                i_reg_write_e,
    input  logic                i_mem_to_reg_e,
    input  logic                i_md_start_e,
    input  logic [REG_ID_W-1:0] i_write_reg_m,
    input  logic                i_reg_write_m,
    input  logic                i_mem_to_reg_m,
    input  logic [REG_ID_W-1:0] i_write_reg_w,
    input  logic                i_reg_write_w,
    output logic                o_stall_f,
    output logic                o_stall_d,
    output logic                o_stall_e,
    output logic                o_flush_e,
    output logic                o_flush_m,
    output logic                o_forward_a_d,
    output logic                o_forward_b_d,
    output logic [1:0]          o_forward_a_e,
    output logic [1:0]          o_forward_b_e,
    output logic                o_md_busy,
    output logic [CNT_W-1:0]    o_stall_cycles
);

    localparam int MD_CNT_W = $clog2(MD_LATENCY) + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_t;

    md_state_t             r_state;
    md_state_t             w_state_nxt;
    logic [MD_CNT_W-1:0]   r_md_cnt;
    logic [MD_CNT_W-1:0]   w_md_cnt_nxt;

    logic       w_run;
    logic       w_lw_stall;
    logic       w_br_stall;
    logic       w_md_busy;
    logic       w_stall_f;
    logic [1:0] w_fwd_a_e;
    logic [1:0] w_fwd_b_e;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic f_match(input logic [REG_ID_W-1:0] a, input logic [REG_ID_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    assign w_run = ~i_reset;

    always_comb begin
        w_fwd_a_e = 2'b00;
        if (i_reg_write_m && f_match(i_write_reg_m, i_rs_id_e))
            w_fwd_a_e = 2'b10;
        else if (i_reg_write_w && f_match(i_write_reg_w, i_rs_id_e))
            w_fwd_a_e = 2'b01;
    end

    always_comb begin
        w_fwd_b_e = 2'b00;
        if (i_reg_write_m && f_match(i_write_reg_m, i_rt_id_e))
            w_fwd_b_e = 2'b10;
        else if (i_reg_write_w && f_match(i_write_reg_w, i_rt_id_e))
            w_fwd_b_e = 2'b01;
    end

    assign w_lw_stall = i_mem_to_reg_e && i_reg_write_e &&
                        (f_match(i_write_reg_e, i_rs_id_d) || f_match(i_write_reg_e, i_rt_id_d));

    assign w_br_stall = i_branch_d &&
                        ((i_reg_write_e &&
                          (f_match(i_write_reg_e, i_rs_id_d) || f_match(i_write_reg_e, i_rt_id_d))) ||
                         (i_mem_to_reg_m &&
                          (f_match(i_write_reg_m, i_rs_id_d) || f_match(i_write_reg_m, i_rt_id_d))));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_md_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    // A new mult/div start seen while busy is dropped; the counter only loads from IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_md_start_e && (MD_LATENCY > 1)) begin
                    w_state_nxt  = S_BUSY;
                    w_md_cnt_nxt = MD_CNT_W'(MD_LATENCY - 1);
                end
            end
            S_BUSY: begin
                if (r_md_cnt == MD_CNT_W'(1)) begin
                    w_state_nxt  = S_IDLE;
                    w_md_cnt_nxt = '0;
                end else begin
                    w_md_cnt_nxt = r_md_cnt - MD_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_md_cnt_nxt = '0;
            end
        endcase
    end

    assign w_md_busy = (r_state == S_BUSY);
    assign w_stall_f = w_run && (w_lw_stall || w_br_stall || w_md_busy);

    // The held ID/EX instruction must survive a busy interlock, so busy masks the flush.
    assign o_stall_f     = w_stall_f;
    assign o_stall_d     = w_stall_f;
    assign o_stall_e     = w_run && w_md_busy;
    assign o_flush_e     = w_run && (w_lw_stall || w_br_stall) && !w_md_busy;
    assign o_flush_m     = w_run && w_md_busy;
    assign o_md_busy     = w_run && w_md_busy;
    assign o_forward_a_d = w_run && i_reg_write_m && f_match(i_write_reg_m, i_rs_id_d);
    assign o_forward_b_d = w_run && i_reg_write_m && f_match(i_write_reg_m, i_rt_id_d);
    assign o_forward_a_e = w_run ? w_fwd_a_e : 2'b00;
    assign o_forward_b_e = w_run ? w_fwd_b_e : 2'b00;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_stall_cycles <= '0;
        else if (w_stall_f && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end

    assign o_stall_cycles = r_stall_cycles;
`else
    assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default build, a MD_LATENCY=1 build and a CNT_W=4 build share stimulus.
module tb_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] rs_id_d, rt_id_d, rs_id_e, rt_id_e, write_reg_e, write_reg_m, write_reg_w;
    logic       branch_d, reg_write_e, mem_to_reg_e, md_start_e;
    logic       reg_write_m, mem_to_reg_m, reg_write_w;

    logic        stall_f, stall_d, stall_e, flush_e, flush_m, fwd_a_d, fwd_b_d, md_busy;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic [31:0] stall_cycles;

    logic        l1_stall_f, l1_stall_d, l1_stall_e, l1_flush_e, l1_flush_m, l1_fwd_a_d, l1_fwd_b_d, l1_md_busy;
    logic [1:0]  l1_fwd_a_e, l1_fwd_b_e;
    logic [31:0] l1_stall_cycles;

    logic        c4_stall_f, c4_stall_d, c4_stall_e, c4_flush_e, c4_flush_m, c4_fwd_a_d, c4_fwd_b_d, c4_md_busy;
    logic [1:0]  c4_fwd_a_e, c4_fwd_b_e;
    logic [3:0]  c4_stall_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    hazard_ctrl dut (
        .i_clock(clock), .i_reset(reset),
        .i_rs_id_d(rs_id_d), .i_rt_id_d(rt_id_d), .i_branch_d(branch_d),
        .i_rs_id_e(rs_id_e), .i_rt_id_e(rt_id_e), .i_write_reg_e(write_reg_e),
        .i_reg_write_e(reg_write_e), .i_mem_to_reg_e(mem_to_reg_e), .i_md_start_e(md_start_e),
        .i_write_reg_m(write_reg_m), .i_reg_write_m(reg_write_m), .i_mem_to_reg_m(mem_to_reg_m),
        .i_write_reg_w(write_reg_w), .i_reg_write_w(reg_write_w),
        .o_stall_f(stall_f), .o_stall_d(stall_d), .o_stall_e(stall_e),
        .o_flush_e(flush_e), .o_flush_m(flush_m),
        .o_forward_a_d(fwd_a_d), .o_forward_b_d(fwd_b_d),
        .o_forward_a_e(fwd_a_e), .o_forward_b_e(fwd_b_e),
        .o_md_busy(md_busy), .o_stall_cycles(stall_cycles)
    );

    hazard_ctrl #(.MD_LATENCY(1)) u_lat1 (
        .i_clock(clock), .i_reset(reset),
        .i_rs_id_d(rs_id_d), .i_rt_id_d(rt_id_d), .i_branch_d(branch_d),
        .i_rs_id_e(rs_id_e), .i_rt_id_e(rt_id_e), .i_write_reg_e(write_reg_e),
        .i_reg_write_e(reg_write_e), .i_mem_to_reg_e(mem_to_reg_e), .i_md_start_e(md_start_e),
        .i_write_reg_m(write_reg_m), .i_reg_write_m(reg_write_m), .i_mem_to_reg_m(mem_to_reg_m),
        .i_write_reg_w(write_reg_w), .i_reg_write_w(reg_write_w),
        .o_stall_f(l1_stall_f), .o_stall_d(l1_stall_d), .o_stall_e(l1_stall_e),
        .o_flush_e(l1_flush_e), .o_flush_m(l1_flush_m),
        .o_forward_a_d(l1_fwd_a_d), .o_forward_b_d(l1_fwd_b_d),
        .o_forward_a_e(l1_fwd_a_e), .o_forward_b_e(l1_fwd_b_e),
        .o_md_busy(l1_md_busy), .o_stall_cycles(l1_stall_cycles)
    );

    hazard_ctrl #(.CNT_W(4)) u_cnt4 (
        .i_clock(clock), .i_reset(reset),
        .i_rs_id_d(rs_id_d), .i_rt_id_d(rt_id_d), .i_branch_d(branch_d),
        .i_rs_id_e(rs_id_e), .i_rt_id_e(rt_id_e), .i_write_reg_e(write_reg_e),
        .i_reg_write_e(reg_write_e), .i_mem_to_reg_e(mem_to_reg_e), .i_md_start_e(md_start_e),
        .i_write_reg_m(write_reg_m), .i_reg_write_m(reg_write_m), .i_mem_to_reg_m(mem_to_reg_m),
        .i_write_reg_w(write_reg_w), .i_reg_write_w(reg_write_w),
        .o_stall_f(c4_stall_f), .o_stall_d(c4_stall_d), .o_stall_e(c4_stall_e),
        .o_flush_e(c4_flush_e), .o_flush_m(c4_flush_m),
        .o_forward_a_d(c4_fwd_a_d), .o_forward_b_d(c4_fwd_b_d),
        .o_forward_a_e(c4_fwd_a_e), .o_forward_b_e(c4_fwd_b_e),
        .o_md_busy(c4_md_busy), .o_stall_cycles(c4_stall_cycles)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rs_id_d = '0; rt_id_d = '0; branch_d = 1'b0;
        rs_id_e = '0; rt_id_e = '0; write_reg_e = '0;
        reg_write_e = 1'b0; mem_to_reg_e = 1'b0; md_start_e = 1'b0;
        write_reg_m = '0; reg_write_m = 1'b0; mem_to_reg_m = 1'b0;
        write_reg_w = '0; reg_write_w = 1'b0;
    endtask

    task automatic set_load_use();
        mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd8; rt_id_d = 5'd8;
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        // Hazards presented during reset must not leak to the outputs.
        set_load_use();
        rs_id_e = 5'd5; reg_write_m = 1'b1; write_reg_m = 5'd5;
        tick(); #1;
        check("rst_stall_f", stall_f, 0);
        check("rst_flush_e", flush_e, 0);
        check("rst_fwd_a_e", fwd_a_e, 0);
        check("rst_md_busy", md_busy, 0);
        check("rst_cnt", stall_cycles, 0);
        clear_inputs();
        tick(); reset = 1'b0; #1;
        check("idle_stall_f", stall_f, 0);

        // Forwarding: MEM over WB, reg 0 ignored
        tick();
        reg_write_m = 1'b1; write_reg_m = 5'd5; reg_write_w = 1'b1; write_reg_w = 5'd5;
        rs_id_e = 5'd5; rt_id_e = 5'd5; #1;
        check("fwd_a_mem_prio", fwd_a_e, 2'b10);
        check("fwd_b_mem_prio", fwd_b_e, 2'b10);
        reg_write_m = 1'b0; #1;
        check("fwd_a_wb", fwd_a_e, 2'b01);
        check("fwd_b_wb", fwd_b_e, 2'b01);
        reg_write_m = 1'b1; write_reg_m = '0; write_reg_w = '0; rs_id_e = '0; rt_id_e = '0; #1;
        check("fwd_a_r0", fwd_a_e, 2'b00);
        check("fwd_b_r0", fwd_b_e, 2'b00);
        write_reg_m = 5'd7; rs_id_e = 5'd7; write_reg_w = 5'd9; rt_id_e = 5'd9; #1;
        check("fwd_a_split", fwd_a_e, 2'b10);
        check("fwd_b_split", fwd_b_e, 2'b01);

        // Load-use
        tick(); clear_inputs(); set_load_use(); #1;
        check("lu_stall_f", stall_f, 1);
        check("lu_stall_d", stall_d, 1);
        check("lu_flush_e", flush_e, 1);
        check("lu_stall_e", stall_e, 0);
        check("lu_flush_m", flush_m, 0);
        mem_to_reg_e = 1'b0; #1;
        check("lu_clr_stall_f", stall_f, 0);
        check("lu_clr_flush_e", flush_e, 0);

        // Branch compare hazards and decode forwarding
        tick(); clear_inputs();
        branch_d = 1'b1; rs_id_d = 5'd3; reg_write_e = 1'b1; write_reg_e = 5'd3; #1;
        check("br_e_stall_f", stall_f, 1);
        check("br_e_flush_e", flush_e, 1);
        tick();
        reg_write_e = 1'b0; write_reg_e = '0;
        reg_write_m = 1'b1; write_reg_m = 5'd3; mem_to_reg_m = 1'b0; #1;
        check("br_m_stall_f", stall_f, 0);
        check("br_fwd_a_d", fwd_a_d, 1);
        check("br_fwd_b_d", fwd_b_d, 0);
        rt_id_d = 5'd3; #1;
        check("br_fwd_b_d_hit", fwd_b_d, 1);
        mem_to_reg_m = 1'b1; #1;
        check("br_mload_stall_f", stall_f, 1);
        branch_d = 1'b0; #1;
        check("nobr_mload_stall_f", stall_f, 0);

        // Mult/div busy for exactly MD_LATENCY-1 cycles
        tick(); clear_inputs(); md_start_e = 1'b1;
        tick(); md_start_e = 1'b0; #1;
        check("md_busy_c1", md_busy, 1);
        check("md_stall_e_c1", stall_e, 1);
        check("md_flush_m_c1", flush_m, 1);
        check("md_stall_f_c1", stall_f, 1);
        check("md_lat1_busy", l1_md_busy, 0);
        tick(); #1;
        check("md_busy_c2", md_busy, 1);
        tick(); #1;
        check("md_busy_c3", md_busy, 1);
        tick(); #1;
        check("md_busy_done", md_busy, 0);
        check("md_stall_e_done", stall_e, 0);
        check("md_flush_m_done", flush_m, 0);

        // Busy start ignored while busy: restart on cycle 2 must not extend the op
        md_start_e = 1'b1;
        tick(); #1;
        check("md2_busy_c1", md_busy, 1);
        tick(); #1;
        md_start_e = 1'b0;
        check("md2_busy_c2", md_busy, 1);
        tick(); #1;
        check("md2_busy_c3", md_busy, 1);
        tick(); #1;
        check("md2_done", md_busy, 0);

        // Reset in the middle of BUSY
        tick(); md_start_e = 1'b1;
        tick(); md_start_e = 1'b0;
        tick(); #1;
        check("mr_busy_c2", md_busy, 1);
        reset = 1'b1; #1;
        check("mr_busy_rst", md_busy, 0);
        check("mr_stall_f_rst", stall_f, 0);
        check("mr_flush_m_rst", flush_m, 0);
        tick(); reset = 1'b0; #1;
        check("mr_busy_rel", md_busy, 0);
        tick(); #1;
        check("mr_stall_e_idle", stall_e, 0);

        // Load-use raised during BUSY: busy dominates, flush re-emerges after
        tick(); md_start_e = 1'b1;
        tick(); md_start_e = 1'b0; set_load_use(); #1;
        check("lub_flush_e_c1", flush_e, 0);
        check("lub_stall_f_c1", stall_f, 1);
        check("lub_stall_e_c1", stall_e, 1);
        check("lub_lat1_flush_e", l1_flush_e, 1);
        tick(); #1;
        check("lub_flush_e_c2", flush_e, 0);
        tick(); #1;
        check("lub_flush_e_c3", flush_e, 0);
        tick(); #1;
        check("lub_flush_e_after", flush_e, 1);
        check("lub_stall_e_after", stall_e, 0);
        check("lub_stall_f_after", stall_f, 1);

        // Stall-cycle counter
        tick(); clear_inputs(); reset = 1'b1;
        tick(); reset = 1'b0; set_load_use(); #1;
        check("cnt_start", stall_cycles, 0);
        repeat (15) tick();
        #1;
`ifdef HAZARD_PERF_EN
        check("cnt_15", stall_cycles, 15);
        check("cnt4_15", c4_stall_cycles, 15);
`else
        check("cnt_off_15", stall_cycles, 0);
        check("cnt4_off_15", c4_stall_cycles, 0);
`endif
        repeat (5) tick();
        #1;
`ifdef HAZARD_PERF_EN
        check("cnt_20", stall_cycles, 20);
        check("cnt4_sat", c4_stall_cycles, 15);
`else
        check("cnt_off_20", stall_cycles, 0);
        check("cnt4_off_20", c4_stall_cycles, 0);
`endif
        clear_inputs();
        tick(); tick(); #1;
`ifdef HAZARD_PERF_EN
        check("cnt_hold", stall_cycles, 20);
`else
        check("cnt_off_hold", stall_cycles, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
